dense_neuron_seq: RTL and testbench
===================================

# dense_neuron_seq

Parametrised, sequential successor of the single-cycle dense neuron core. Computes one neuron output `y = act(sat(sum(x[i]*w[i]) + bias))` over `N_IN` inputs. Operands are streamed in `LANES`-wide beats over a valid/ready handshake and reduced by a folded MAC. Supports fixed-point scaling, saturation and optional ReLU. Sits between the layer's input/weight buffer and the activation write-back path.

## Interface
- `DATA_W`, 32: width of x, w, bias and output (signed two's complement).
- `N_IN`, 64: inputs per neuron. Must be a multiple of `LANES`.
- `LANES`, 8: products per beat. `BEATS = N_IN/LANES`.
- `FRAC_BITS`, 0: fractional bits of the Q format (x, w, bias, output share it).
- `ACC_W`, 72: accumulator width. Must be ≥ `2*DATA_W + $clog2(N_IN) + 1`, so the accumulator never wraps.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `soft_clr` in 1: synchronous abort. Returns to IDLE and discards the partial sum.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `in_x` in `DATA_W` × `LANES`: input slice, lane k = element `beat*LANES+k`.
- `in_w` in `DATA_W` × `LANES`: weight slice, same indexing.
- `in_bias` in `DATA_W`: bias, sampled on the first beat only.
- `relu_en` in 1: ReLU enable, sampled on the first beat only.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_data` out `DATA_W`: neuron result.
- `out_sat` out 1: result was clipped by saturation (before ReLU).

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE: `in_ready=1`, `out_valid=0`. On an accepted beat:
  - `acc <= (sext(in_bias) <<< FRAC_BITS) + lane_sum`.
  - Latch `relu_en`; `beat_cnt <= 1`.
  - Go to ACCUM, or straight to OUT if `BEATS==1`.
- ACCUM: `in_ready=1`. On an accepted beat: `acc <= acc + lane_sum`; `beat_cnt++`. On the beat where `beat_cnt==BEATS-1`, go to OUT and load the output register. Cycles with no beat hold all state.
- `lane_sum`: sum of the `LANES` full-precision `2*DATA_W` signed products, sign-extended to `ACC_W`.
- Output formation, registered on entry to OUT:
  - `r = (acc + lane_sum) >>> FRAC_BITS`, arithmetic shift, truncation toward −∞.
  - If `r > 2^(DATA_W-1)-1` → max, `out_sat=1`. If `r < -2^(DATA_W-1)` → min, `out_sat=1`.
  - Then, if latched `relu_en` and the value is negative → 0. `out_sat` keeps its saturation value.
- OUT: `in_ready=0`, `out_valid=1`. `out_data` and `out_sat` stay stable until `out_ready`; on handshake go to IDLE. There is no overlap between neurons.
- `soft_clr` has priority over every handshake in the same cycle:
  - next state IDLE, `acc=0`, `beat_cnt=0`, `out_valid=0`.
  - A beat or output handshake coinciding with `soft_clr` is discarded.
- Reset values: state IDLE, `acc=0`, `beat_cnt=0`, `out_valid=0`, `out_data=0`, `out_sat=0`. `in_ready` reads 1 from the first cycle after reset deasserts.
- Mid-operation reset: the partial sum is lost and no `out_valid` is produced for that neuron.

## Timing
- `in_ready` is a function of state only, with no combinational path from `in_valid` or `out_ready`.
- With back-to-back beats, `out_valid` rises the cycle after the last beat is accepted. Latency from first beat to `out_valid` is `BEATS` cycles (8 at defaults).
- Throughput: one neuron per `BEATS+1` cycles when `out_ready` is held high.
- Products and lane sum are combinational within the accept cycle; the only registers are `acc`, `beat_cnt`, state and the output register.

## Structure
- Package `dense_pkg`:
  - state enum `dense_state_t` {IDLE, ACCUM, OUT};
  - parameter-check helper for `ACC_W`;
  - saturation function `sat_trunc(acc, FRAC_BITS, DATA_W)`.
- Sub-module `dense_lane_mac`: `LANES` signed multipliers plus adder tree, output `lane_sum` at `ACC_W`. Purely combinational; instantiated once.
- Top module holds the FSM, beat counter, accumulator and output register.
- Elaboration-time assertions: `N_IN % LANES == 0`, `ACC_W` bound, `FRAC_BITS < DATA_W`.

## Test plan
- Integer identity, defaults:
  - Stimulus: x[i]=i, w[i]=1, bias=10, 8 back-to-back beats.
  - Response: `out_data=2026`, `out_sat=0`, `out_valid` in the cycle after beat 8.
- Saturation:
  - Stimulus: all x=w=0x7FFFFFFF, bias=0.
  - Response: `out_data=0x7FFFFFFF`, `out_sat=1`.
  - Repeat with w=0x80000000. Response: `out_data=0x80000000`, `out_sat=1`.
- ReLU and Q format, `FRAC_BITS=8`:
  - Stimulus: x=−256 (−1.0), w=256 (1.0) for all 64, bias=0, `relu_en=1`.
  - Response: `out_data=0`, `out_sat=0`. With `relu_en=0`, `out_data=−16384` (−64.0).
- Handshake stalls:
  - Stimulus: random `in_valid` gaps; `out_ready` held low 5 cycles.
  - Response: result unchanged versus the no-stall run; `out_data` stable while stalled; `in_ready=0` throughout OUT.
- `soft_clr` mid-neuron:
  - Stimulus: assert after beat 4, then stream a fresh neuron (x=1, w=2, bias=−5).
  - Response: no output for the aborted neuron; next output is 123.
- Async reset:
  - Stimulus: `rst_n` low during ACCUM and again during OUT with `out_ready=0`.
  - Response: all outputs at reset values immediately; a clean neuron afterwards is correct.

Source files
------------

// File: rtl/dense_neuron_seq_pkg.sv
// Shared types and helpers for the sequential dense neuron: FSM state encoding,
// accumulator width check and the shift/saturate step used at result formation.
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } dense_state_t;

    localparam int MAX_ACC_W  = 128;
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic                  sat;
        logic [MAX_DATA_W-1:0] val;
    } sat_res_t;

    // True when the accumulator can absorb N_IN full-precision products plus bias.
    function automatic bit acc_w_ok(input int acc_w, input int data_w, input int n_in);
        return acc_w >= (2 * data_w + $clog2(n_in) + 1);
    endfunction

    // Arithmetic right shift (floor), then clip to the signed data_w range.
    function automatic sat_res_t sat_trunc(input logic signed [MAX_ACC_W-1:0] acc,
                                           input int frac_bits, input int data_w);
        logic signed [MAX_ACC_W-1:0] r;
        logic signed [MAX_ACC_W-1:0] max_v;
        logic signed [MAX_ACC_W-1:0] min_v;
        sat_res_t res;
        r     = acc >>> frac_bits;
        max_v = $signed((128'd1 << (data_w - 1)) - 128'd1);
        min_v = -max_v - 128'sd1;
        res.sat = 1'b0;
        res.val = r[MAX_DATA_W-1:0];
        if (r > max_v) begin
            res.sat = 1'b1;
            res.val = max_v[MAX_DATA_W-1:0];
        end else if (r < min_v) begin
            res.sat = 1'b1;
            res.val = min_v[MAX_DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dense_neuron_seq_lane_mac.sv
// One beat worth of signed products, summed at accumulator width. Purely combinational.
module dense_lane_mac #(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int ACC_W  = 72
) (
    input  logic [LANES-1:0][DATA_W-1:0] i_x,
    input  logic [LANES-1:0][DATA_W-1:0] i_w,
    output logic signed [ACC_W-1:0]      o_lane_sum
);

    logic signed [2*DATA_W-1:0] w_prod [LANES];

    always_comb begin
        o_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_prod[k]  = $signed(i_x[k]) * $signed(i_w[k]);
            o_lane_sum = o_lane_sum + ACC_W'(w_prod[k]);
        end
    end

endmodule

// File: rtl/dense_neuron_seq.sv
// Sequential dense neuron: streams LANES-wide beats into a folded MAC and emits
// act(sat(sum(x*w) + bias)) once per neuron over a valid/ready output port.
module dense_neuron_seq
    import dense_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_IN      = 64,
    parameter int LANES     = 8,
    parameter int FRAC_BITS = 0,
    parameter int ACC_W     = 72
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         soft_clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][DATA_W-1:0] in_x,
    input  logic [LANES-1:0][DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0]            in_bias,
    input  logic                         relu_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sat,
    output logic [1:0]                   o_dbg_state
);

    localparam int BEATS = N_IN / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);

    if (N_IN % LANES != 0) begin : g_bad_lanes
        $error("N_IN must be a multiple of LANES");
    end
    if (!acc_w_ok(ACC_W, DATA_W, N_IN) || ACC_W > MAX_ACC_W) begin : g_bad_acc
        $error("ACC_W too narrow for N_IN products, or wider than MAX_ACC_W");
    end
    if (FRAC_BITS >= DATA_W || DATA_W > MAX_DATA_W) begin : g_bad_frac
        $error("FRAC_BITS must be below DATA_W, DATA_W at most MAX_DATA_W");
    end

    dense_state_t             r_state;
    dense_state_t             w_next_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic                     r_relu;
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_sat;

    logic signed [ACC_W-1:0]  w_lane_sum;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_relu_eff;
    sat_res_t                 w_sat_res;
    logic [DATA_W-1:0]        w_out_val;

    dense_lane_mac #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_lane_mac (
        .i_x        (in_x),
        .i_w        (in_w),
        .o_lane_sum (w_lane_sum)
    );

    // The first beat seeds the accumulator with the scaled bias instead of the old sum.
    assign w_acc_base = (r_state == IDLE) ? (ACC_W'($signed(in_bias)) <<< FRAC_BITS) : r_acc;
    assign w_acc_sum  = w_acc_base + w_lane_sum;
    assign w_accept   = in_valid & in_ready;
    assign w_last     = (r_state == IDLE) ? (BEATS == 1) : (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_relu_eff = (r_state == IDLE) ? relu_en : r_relu;

    assign w_sat_res = sat_trunc({{(MAX_ACC_W-ACC_W){w_acc_sum[ACC_W-1]}}, w_acc_sum},
                                 FRAC_BITS, DATA_W);
    assign w_out_val = (w_relu_eff && w_sat_res.val[DATA_W-1]) ? '0 : w_sat_res.val[DATA_W-1:0];

    always_comb begin
        w_next_state = r_state;
        in_ready     = (r_state != OUT);
        out_valid    = (r_state == OUT);
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_last ? OUT : ACCUM;
            ACCUM:   if (w_accept && w_last) w_next_state = OUT;
            OUT:     if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (soft_clr) w_next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_relu     <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (soft_clr) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_acc      <= w_acc_sum;
                r_beat_cnt <= (r_state == IDLE) ? CNT_W'(1) : r_beat_cnt + CNT_W'(1);
                if (r_state == IDLE) r_relu <= relu_en;
                if (w_last) begin
                    r_out_data <= w_out_val;
                    r_out_sat  <= w_sat_res.sat;
                end
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dense_neuron_seq.sv
// Directed bench for dense_neuron_seq: an integer instance and a Q8 instance share
// all stimulus; each step checks hand-computed results with immediate assertions.
module tb_dense_neuron_seq;

    localparam int DW = 32;
    localparam int LN = 8;
    localparam int NI = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  soft_clr;
    logic                  in_valid;
    logic                  out_ready;
    logic [LN-1:0][DW-1:0] in_x;
    logic [LN-1:0][DW-1:0] in_w;
    logic [DW-1:0]         in_bias;
    logic                  relu_en;

    logic                  in_ready,   q_in_ready;
    logic                  out_valid,  q_out_valid;
    logic [DW-1:0]         out_data,   q_out_data;
    logic                  out_sat,    q_out_sat;
    logic [1:0]            dbg_state,  q_dbg_state;

    logic [DW-1:0] xv [NI];
    logic [DW-1:0] wv [NI];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dense_neuron_seq u_dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .in_bias(in_bias), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .o_dbg_state(dbg_state)
    );

    dense_neuron_seq #(.FRAC_BITS(8)) u_dut_q (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_valid(in_valid), .in_ready(q_in_ready), .in_x(in_x), .in_w(in_w),
        .in_bias(in_bias), .relu_en(relu_en),
        .out_valid(q_out_valid), .out_ready(out_ready), .out_data(q_out_data),
        .out_sat(q_out_sat), .o_dbg_state(q_dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic fill(input logic [DW-1:0] x_const, input logic [DW-1:0] w_const,
                        input bit x_is_index);
        for (int i = 0; i < NI; i++) begin
            xv[i] = x_is_index ? DW'(i) : x_const;
            wv[i] = w_const;
        end
    endtask

    // Drives nbeats beats starting at a negedge; random idle gaps up to max_gap.
    task automatic drive_neuron(input logic [DW-1:0] bias, input logic relu,
                                input int max_gap, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            chk("idle_before_beat_out_valid", 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            in_bias  = bias;
            relu_en  = relu;
            for (int k = 0; k < LN; k++) begin
                in_x[k] = xv[b*LN + k];
                in_w[k] = wv[b*LN + k];
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_consume_out_valid", 64'(out_valid), 64'd0);
        chk("after_consume_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_w = '0; in_bias = '0; relu_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_sat", 64'(out_sat), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Integer identity: sum(0..63) + 10
        fill('0, 32'd1, 1'b1);
        drive_neuron(32'd10, 1'b0, 0, 8);
        chk("ident_out_valid_after_beat8", 64'(out_valid), 64'd1);
        chk("ident_in_ready_in_out", 64'(in_ready), 64'd0);
        chk("ident_out_data", 64'(out_data), 64'd2026);
        chk("ident_out_sat", 64'(out_sat), 64'd0);
        consume();

        // Positive saturation
        fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        drive_neuron(32'd0, 1'b0, 0, 8);
        chk("satpos_out_data", 64'(out_data), 64'h7FFF_FFFF);
        chk("satpos_out_sat", 64'(out_sat), 64'd1);
        consume();

        // Negative saturation
        fill(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        drive_neuron(32'd0, 1'b0, 0, 8);
        chk("satneg_out_data", 64'(out_data), 64'h8000_0000);
        chk("satneg_out_sat", 64'(out_sat), 64'd1);
        consume();

        // Q8: -1.0 * 1.0 * 64 = -64.0, clipped to 0 by ReLU
        fill(32'hFFFF_FF00, 32'd256, 1'b0);
        drive_neuron(32'd0, 1'b1, 0, 8);
        chk("q8_relu_out_valid", 64'(q_out_valid), 64'd1);
        chk("q8_relu_out_data", 64'(q_out_data), 64'd0);
        chk("q8_relu_out_sat", 64'(q_out_sat), 64'd0);
        consume();
        drive_neuron(32'd0, 1'b0, 0, 8);
        chk("q8_norelu_out_data", 64'(q_out_data), 64'hFFFF_C000);
        chk("q8_norelu_out_sat", 64'(q_out_sat), 64'd0);
        consume();

        // Stalls on both sides
        fill('0, 32'd1, 1'b1);
        drive_neuron(32'd10, 1'b0, 3, 8);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_data_stable", 64'(out_data), 64'd2026);
            chk("stall_out_valid_held", 64'(out_valid), 64'd1);
            chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        end
        consume();

        // soft_clr after beat 4, with a coinciding beat that must be dropped
        drive_neuron(32'd10, 1'b0, 0, 4);
        soft_clr = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        fill(32'd1, 32'd2, 1'b0);
        drive_neuron(32'hFFFF_FFFB, 1'b0, 0, 8);
        chk("clr_next_out_valid", 64'(out_valid), 64'd1);
        chk("clr_next_out_data", 64'(out_data), 64'd123);
        consume();

        // Async reset during ACCUM
        fill('0, 32'd1, 1'b1);
        drive_neuron(32'd10, 1'b0, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_accum_out_valid", 64'(out_valid), 64'd0);
        chk("arst_accum_out_data", 64'(out_data), 64'd0);
        chk("arst_accum_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset while holding a result in OUT
        drive_neuron(32'd10, 1'b0, 0, 8);
        chk("arst_out_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_out_data", 64'(out_data), 64'd0);
        chk("arst_out_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill(32'd1, 32'd2, 1'b0);
        drive_neuron(32'hFFFF_FFFB, 1'b0, 0, 8);
        chk("post_arst_out_valid", 64'(out_valid), 64'd1);
        chk("post_arst_out_data", 64'(out_data), 64'd123);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
